// File: rtl/sha1_sched_if.sv
// Word-stream, core-side and result signals of the SHA-1 block sequencer.
// The slave modport is the sequencer; the master side drives the stream and the core.
`timescale 1ns/1ps
interface sha1_sched_if #(
  parameter int CNT_W = 16
);
  logic             init;
  logic [31:0]      word_in;
  logic             word_valid;
  logic             word_last;
  logic             word_ready;
  logic             core_restart;
  logic [159:0]     core_h;
  logic [31:0]      core_word;
  logic [3:0]       core_raddr;
  logic [159:0]     core_abcde;
  logic             core_ready;
  logic [159:0]     digest;
  logic             digest_valid;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;

  modport slave (
    input  init, word_in, word_valid, word_last, core_raddr, core_abcde, core_ready,
    output word_ready, core_restart, core_h, core_word, digest, digest_valid, busy, blk_cnt
  );

  modport master (
    output init, word_in, word_valid, word_last, core_raddr, core_abcde, core_ready,
    input  word_ready, core_restart, core_h, core_word, digest, digest_valid, busy, blk_cnt
  );
endinterface

// File: rtl/sha1_sched.sv
// Multi-block sequencer for the sha1block core: buffers one 16-word block, runs the core,
// folds the result into the chaining state and presents the final digest.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   LOAD   | accept words into the buffer until word 15 is taken
//   START  | one-cycle core_restart, arm the stale-ready guard
//   WAIT   | count guard down, then wait for core_ready
//   UPDATE | add core result to H; publish digest on the last block
`timescale 1ns/1ps
module sha1_sched #(
  parameter int CNT_W = 16,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  sha1_sched_if.slave bus
);

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {LOAD, START, WAIT, UPDATE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wcnt;
  logic [31:0]      wbuf [16];
  logic             last_blk;
  logic [GW-1:0]    guard;
  logic [159:0]     h;
  logic [159:0]     sum;
  logic [CNT_W-1:0] cnt;
  logic [159:0]     dig;
  logic             dvalid;
  logic             accept;
  logic             init_ok;

  assign accept  = (state == LOAD) && bus.word_valid;
  assign init_ok = (state == LOAD) && (wcnt == 4'd0) && bus.init;

  // Lanes add independently; carries never cross a 32-bit boundary.
  for (genvar i = 0; i < 5; i++) begin : g_lane
    assign sum[32*i +: 32] = h[32*i +: 32] + bus.core_abcde[32*i +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.word_ready   = 1'b0;
    bus.core_restart = 1'b0;
    bus.busy         = 1'b1;
    case (state)
      LOAD: begin
        bus.word_ready = !rst;
        bus.busy       = 1'b0;
        if (accept && wcnt == 4'd15) state_nxt = START;
      end
      START: begin
        bus.core_restart = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (guard == '0 && bus.core_ready) state_nxt = UPDATE;
      end
      UPDATE: state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= 4'd0;
      last_blk <= 1'b0;
      guard    <= '0;
      h        <= IV;
      cnt      <= '0;
      dig      <= '0;
      dvalid   <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      case (state)
        LOAD: begin
          if (init_ok) begin
            h   <= IV;
            cnt <= '0;
          end
          if (accept) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd15) last_blk <= bus.word_last;
          end
        end
        START: guard <= GW'(GUARD);
        WAIT: if (guard != '0) guard <= guard - GW'(1);
        UPDATE: begin
          cnt  <= cnt + CNT_W'(1);
          wcnt <= 4'd0;
          if (last_blk) begin
            dig    <= sum;
            dvalid <= 1'b1;
            h      <= IV;
          end else begin
            h <= sum;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer is only written in LOAD, so it stays stable while the core reads it.
  always_ff @(posedge clk) begin
    if (accept) wbuf[wcnt] <= bus.word_in;
  end

  assign bus.core_word    = wbuf[bus.core_raddr];
  assign bus.core_h       = h;
  assign bus.digest       = dig;
  assign bus.digest_valid = dvalid;
  assign bus.blk_cnt      = cnt;

endmodule

// File: tb/tb_sha1_sched.sv
// Bench for sha1_sched: behavioural SHA-1 core model, word-stream driver and a digest
// scoreboard compared against known SHA-1 test vectors.
`timescale 1ns/1ps
module tb_sha1_sched;
  localparam int CNT_W = 16;
  localparam int GUARD = 2;
  localparam logic [159:0] IV    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] D_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha1_sched_if #(.CNT_W(CNT_W)) bus();
  sha1_sched #(.CNT_W(CNT_W), .GUARD(GUARD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [159:0]     dig;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_fail = 0;
  int           blk_sent = 0;
  bit           stale_mode = 1'b0;
  logic [31:0]  msg [48];
  logic [31:0]  rd_w [16];
  logic [159:0] hsnap, mres;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] sha1_abcde(input logic [159:0] hin);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = rd_w[t];
      else begin
        tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
        w[t] = {tmp[30:0], tmp[31]};
      end
    end
    {a, b, c, d, e} = hin;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {a, b, c, d, e};
  endfunction

  // Core model: reads the block by address, answers after a random latency, keeps ready
  // high until the next restart (stale_mode holds it through START and two WAIT cycles).
  initial begin
    bus.core_raddr = 4'd0;
    bus.core_abcde = '0;
    bus.core_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.core_restart) begin
        hsnap = bus.core_h;
        if (stale_mode) begin
          repeat (3) @(posedge clk);
          #1;
        end
        bus.core_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
          bus.core_raddr = 4'(i);
          #0.1;
          rd_w[i] = bus.core_word;
        end
        mres = sha1_abcde(hsnap);
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        bus.core_abcde = mres;
        bus.core_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.digest_valid) begin
      if (sb.size() == 0) chk("spurious_digest_valid", 1'b1, 1'b0);
      else begin
        mon_e = sb.pop_front();
        chk("digest", bus.digest, mon_e.dig);
        chk("blk_cnt_at_digest", bus.blk_cnt, mon_e.cnt);
      end
    end
  end

  task automatic send_block(input int base, input bit last, input logic [159:0] expd,
                            input bit gaps, input int junk_idx, input int init_idx);
    exp_t e;
    if (init_idx == 0) blk_sent = 0;
    if (last) begin
      e.dig = expd;
      e.cnt = CNT_W'(blk_sent + 1);
      sb.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      int t;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.word_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.word_in    = msg[base + i];
      bus.word_valid = 1'b1;
      bus.word_last  = (i == 15) ? last : (i == junk_idx);
      bus.init       = (i == init_idx);
      t = 0;
      while (!bus.word_ready && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 300) chk("word_ready_timeout", bus.word_ready, 1'b1);
      @(posedge clk); #1;
      bus.word_valid = 1'b0;
      bus.word_last  = 1'b0;
      bus.init       = 1'b0;
    end
    blk_sent++;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("digest_timeout", 160'(sb.size()), 160'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 48; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    msg[16] = 32'h61626364; msg[17] = 32'h62636465; msg[18] = 32'h63646566; msg[19] = 32'h64656667;
    msg[20] = 32'h65666768; msg[21] = 32'h66676869; msg[22] = 32'h6768696a; msg[23] = 32'h68696a6b;
    msg[24] = 32'h696a6b6c; msg[25] = 32'h6a6b6c6d; msg[26] = 32'h6b6c6d6e; msg[27] = 32'h6c6d6e6f;
    msg[28] = 32'h6d6e6f70; msg[29] = 32'h6e6f7071; msg[30] = 32'h80000000;
    msg[47] = 32'h000001c0;

    bus.init = 1'b0; bus.word_in = '0; bus.word_valid = 1'b0; bus.word_last = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_digest", bus.digest, 160'd0);
    chk("rst_digest_valid", bus.digest_valid, 1'b0);
    chk("rst_core_restart", bus.core_restart, 1'b0);
    chk("rst_blk_cnt", bus.blk_cnt, 160'd0);
    chk("rst_core_h", bus.core_h, IV);
    chk("rst_word_ready", bus.word_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("word_ready_after_rst", bus.word_ready, 1'b1);

    // Single block "abc", plus the START cycle outputs
    send_block(0, 1'b1, D_ABC, 1'b0, -1, -1);
    chk("start_restart", bus.core_restart, 1'b1);
    chk("start_busy", bus.busy, 1'b1);
    chk("start_word_ready", bus.word_ready, 1'b0);
    chk("start_core_h", bus.core_h, IV);
    @(posedge clk); #1;
    chk("restart_one_cycle", bus.core_restart, 1'b0);
    wait_idle();

    // Plain init pulse, then the two-block message
    bus.init = 1'b1;
    @(posedge clk); #1;
    bus.init = 1'b0;
    blk_sent = 0;
    chk("init_blk_cnt", bus.blk_cnt, 160'd0);
    send_block(16, 1'b0, '0, 1'b0, -1, -1);
    send_block(32, 1'b1, D_TWO, 1'b0, -1, -1);
    wait_idle();

    // Back-to-back: two-block message then "abc", no init between
    send_block(16, 1'b0, '0, 1'b0, -1, -1);
    send_block(32, 1'b1, D_TWO, 1'b0, -1, -1);
    send_block(0, 1'b1, D_ABC, 1'b0, -1, -1);
    wait_idle();

    // Random gaps, stray word_last on word 3, init mid-block (both ignored)
    send_block(16, 1'b0, '0, 1'b1, 3, -1);
    send_block(32, 1'b1, D_TWO, 1'b1, -1, 5);
    wait_idle();

    // Init together with the first word, after a non-final block
    send_block(16, 1'b0, '0, 1'b0, -1, -1);
    send_block(0, 1'b1, D_ABC, 1'b0, -1, 0);
    wait_idle();

    // Stale core_ready held through START and two cycles after
    stale_mode = 1'b1;
    send_block(0, 1'b1, D_ABC, 1'b0, -1, -1);
    wait_idle();
    stale_mode = 1'b0;

    // Reset while waiting on the core, then "abc"
    send_block(0, 1'b1, D_ABC, 1'b0, -1, -1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("wait_rst_busy", bus.busy, 1'b0);
    chk("wait_rst_blk_cnt", bus.blk_cnt, 160'd0);
    chk("wait_rst_digest", bus.digest, 160'd0);
    chk("wait_rst_core_h", bus.core_h, IV);
    chk("wait_rst_word_ready", bus.word_ready, 1'b0);
    sb.delete();
    blk_sent = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("wait_rst_release_ready", bus.word_ready, 1'b1);
    send_block(0, 1'b1, D_ABC, 1'b0, -1, -1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha1_sched.md
Name: sha1_sched

Overview:
Multi-block sequencer for the sha1block compression core. It buffers one 512-bit message block from an upstream word stream and serves words to the core by read address. It starts the core, keeps the 160-bit chaining state across blocks and folds the core result into it, then presents the final digest. Padding is done upstream; this block sees only whole 16-word blocks plus a last-block marker.

Parameters:
CNT_W, 16, width of the processed-block counter
GUARD, 2, cycles after core_restart during which core_ready is ignored (stale ready from the previous block)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
init  in  1  pulse: reload chaining state with the SHA-1 IV
word_in  in  32  message word, big-endian, first word of the block first
word_valid  in  1  word_in valid
word_last  in  1  qualifies the 16th word of a block: this block ends the message
word_ready  out  1  block accepts word_in this cycle
core_restart  out  1  one-cycle start pulse to sha1block
core_h  out  160  {h0,h1,h2,h3,h4} chaining input to the core
core_word  out  32  buffer word at core_raddr (combinational read)
core_raddr  in  4  core word read address
core_abcde  in  160  {a,b,c,d,e} from the core
core_ready  in  1  core compression done
digest  out  160  final hash, held until the next final update
digest_valid  out  1  one-cycle pulse when digest updates
busy  out  1  high in every state except LOAD
blk_cnt  out  CNT_W  blocks compressed since the last reset or init, wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, active-high) and init both do the following: H = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0 and blk_cnt = 0. Reset also clears the word count and sets state LOAD. Reset also clears digest to 0 and digest_valid, core_restart and busy to 0; word_ready goes to 1 when reset is released.
- Reset mid-operation abandons the block. The core is not waited on.
- States: LOAD, START, WAIT, UPDATE.
- LOAD:
  - word_ready = 1.
  - On word_valid, buf[wcnt] <= word_in and wcnt increments.
  - word_last is sampled only when wcnt == 15; it is ignored on other words.
  - Accepting word 15 goes to START and latches last_blk.
- init: honoured only in LOAD with wcnt == 0. It is ignored elsewhere.
- Simultaneous init and a first word: init applies and the word is accepted.
- START:
  - core_restart = 1 for exactly one cycle.
  - Load guard = GUARD, then go to WAIT.
- WAIT:
  - Decrement guard to 0.
  - When guard == 0 and core_ready == 1, go to UPDATE.
  - core_ready high while guard != 0 is ignored.
- core_word = buf[core_raddr] in all states. The buffer is not written outside LOAD, so it is stable for the whole compression.
- UPDATE (one cycle):
  - sum_i = H_i + core_abcde_i, modulo 2^32 per lane, no carry between lanes.
  - blk_cnt increments.
  - If last_blk: digest <= sum, digest_valid = 1 the next cycle, H <= IV, then go to LOAD.
  - Otherwise: H <= sum and go to LOAD.
  - wcnt = 0 on re-entry to LOAD.
- core_h = H, held constant from START through WAIT.
- word_ready = 0 in START, WAIT and UPDATE. Upstream stalls and nothing is dropped.
- Latency: from the 16th accepted word to digest_valid = 1 (START) + GUARD + core compute + 1 (UPDATE) + 1 cycle.
- Gaps in word_valid are allowed at any word index and only stretch LOAD.

Test Plan:
- Single block "abc": 61626380, 14 × 0, 00000018 with word_last on the 16th word, core = real sha1block with nrst = ~rst -> one digest_valid pulse, digest = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, blk_cnt = 1.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": padded, word_last only on the second block -> no pulse after block 1, then digest = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1, blk_cnt = 2.
- Back-to-back: the two-block message then "abc" with no init between -> second digest = a9993e36… (IV auto-reload).
- Random word_valid gaps plus word_last asserted on word 3 of block 1 -> word_last ignored, results identical to the previous test.
- Stale ready: core model holding core_ready = 1 through START and two cycles after -> no UPDATE before the guard expires.
- Reset asserted in WAIT -> outputs at reset values immediately; "abc" afterwards -> correct digest.
